// File: rtl/tmr0_timer.sv
// tmr0_timer: PIC-style TMR0 counter with OPTION register, shared prescaler,
// external-pin synchroniser and a two-cycle write inhibit.
module tmr0_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cycle_en,
  input  logic [7:0] data_in,
  input  logic       tmr0_reg_wr_en,
  input  logic       option_reg_wr_en,
  input  logic       t0cki,
  output logic [7:0] tmr0_reg_val,
  output logic [7:0] option_reg_val,
  output logic       t0if_set
);
  typedef enum logic [1:0] {IDLE, INH2, INH1} inh_t;
  inh_t inh;
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic [7:0] pre;
  logic [8:0] span;
  logic ext, evt, tick;
  always_comb begin
    ext  = option_reg_val[4] ? (prev & ~sync[SYNC_STAGES-1]) : (~prev & sync[SYNC_STAGES-1]);
    evt  = option_reg_val[5] ? ext : cycle_en;
    span = (9'd2 << option_reg_val[2:0]) - 9'd1;
    tick = evt & (option_reg_val[3] | ((pre & span[7:0]) == span[7:0])) & (inh == IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync           <= '0;
      prev           <= 1'b0;
      pre            <= '0;
      inh            <= IDLE;
      tmr0_reg_val   <= '0;
      option_reg_val <= 8'hFF;
      t0if_set       <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], t0cki};
      prev <= sync[SYNC_STAGES-1];
      if (option_reg_wr_en) option_reg_val <= data_in;
      // the prescaler keeps counting through the inhibit window
      if (tmr0_reg_wr_en || option_reg_wr_en) pre <= '0;
      else if (evt && !option_reg_val[3]) pre <= pre + 8'd1;
      if (tmr0_reg_wr_en) tmr0_reg_val <= data_in;
      else if (tick) tmr0_reg_val <= tmr0_reg_val + 8'd1;
      t0if_set <= !tmr0_reg_wr_en && tick && (tmr0_reg_val == 8'hFF);
      if (tmr0_reg_wr_en) inh <= INH2;
      else if (cycle_en) inh <= (inh == INH2) ? INH1 : IDLE;
    end
  end
endmodule

// File: tb/tb_tmr0_timer.sv
// tb_tmr0_timer: directed scenarios plus randomized traffic against a
// behavioural model of the timer.
module tb_tmr0_timer;
  localparam int S = 2;
  logic clk = 0, rst = 0, cycle_en = 0, tmr0_reg_wr_en = 0, option_reg_wr_en = 0, t0cki = 0;
  logic [7:0] data_in = 0, tmr0_reg_val, option_reg_val;
  logic t0if_set;
  int checks = 0, failures = 0, if_cnt = 0;

  tmr0_timer #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cycle_en(cycle_en), .data_in(data_in),
    .tmr0_reg_wr_en(tmr0_reg_wr_en), .option_reg_wr_en(option_reg_wr_en),
    .t0cki(t0cki), .tmr0_reg_val(tmr0_reg_val), .option_reg_val(option_reg_val),
    .t0if_set(t0if_set)
  );

  always #5 clk = ~clk;

  // reference model: pin history, prescaler as an integer count, inhibit as a counter
  int m_tmr = 0, m_pre = 0, m_inh = 0;
  logic [7:0] m_opt = 8'hFF;
  logic m_if = 0;
  logic [S:0] hist = '0;
  always @(posedge clk) begin
    if (!rst) begin
      m_tmr = 0; m_opt = 8'hFF; m_pre = 0; m_inh = 0; m_if = 0; hist = '0;
    end else begin
      automatic logic cur = hist[S-1], old = hist[S], evt, tick, blocked;
      automatic int period = 1 << (m_opt[2:0] + 1);
      evt = m_opt[5] ? (m_opt[4] ? (old && !cur) : (!old && cur)) : cycle_en;
      tick = evt && (m_opt[3] || (m_pre % period) == period - 1);
      if (evt && !m_opt[3]) m_pre = (m_pre + 1) % 256;
      blocked = m_inh > 0;
      if (cycle_en && m_inh > 0) m_inh--;
      m_if = 0;
      if (tmr0_reg_wr_en) begin
        m_tmr = data_in; m_pre = 0; m_inh = 2;
      end else if (tick && !blocked) begin
        m_if = (m_tmr == 255);
        m_tmr = (m_tmr + 1) % 256;
      end
      if (option_reg_wr_en) begin m_opt = data_in; m_pre = 0; end
      hist = {hist[S-1:0], t0cki};
    end
  end

  task automatic cyc(input logic ce, input logic tw, input logic ow, input logic [7:0] d);
    cycle_en = ce; tmr0_reg_wr_en = tw; option_reg_wr_en = ow; data_in = d;
    @(posedge clk); #1;
    cycle_en = 0; tmr0_reg_wr_en = 0; option_reg_wr_en = 0;
    if (t0if_set) if_cnt++;
  endtask

  task automatic test_reset;
    rst = 0;
    cyc(1, 1, 1, 8'h55);
    cyc(1, 1, 1, 8'h55);
    checks++; if (tmr0_reg_val !== 8'h00) begin failures++; $display("FAIL reset_tmr0 got=%h exp=00", tmr0_reg_val); end
    checks++; if (option_reg_val !== 8'hFF) begin failures++; $display("FAIL reset_option got=%h exp=FF", option_reg_val); end
    checks++; if (t0if_set !== 1'b0) begin failures++; $display("FAIL reset_t0if got=%b exp=0", t0if_set); end
    rst = 1;
    cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h00) begin failures++; $display("FAIL reset_no_count got=%h exp=00", tmr0_reg_val); end
  endtask

  task automatic test_inhibit_overflow;
    logic [7:0] exp [5] = '{8'hFD, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    cyc(0, 0, 1, 8'h08);
    cyc(0, 1, 0, 8'hFD);
    if_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      checks++; if (tmr0_reg_val !== exp[i]) begin failures++; $display("FAIL inhibit_seq[%0d] got=%h exp=%h", i, tmr0_reg_val, exp[i]); end
      if (i == 3) begin
        checks++; if (t0if_set !== 1'b0) begin failures++; $display("FAIL t0if_early got=%b exp=0", t0if_set); end
      end
    end
    checks++; if (t0if_set !== 1'b1) begin failures++; $display("FAIL t0if_with_00 got=%b exp=1", t0if_set); end
    cyc(0, 0, 0, 0);
    checks++; if (t0if_set !== 1'b0 || if_cnt != 1) begin failures++; $display("FAIL t0if_once got=%b cnt=%0d exp=0 cnt=1", t0if_set, if_cnt); end
  endtask

  task automatic test_prescale_1to8;
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h02);
    repeat (24) cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h03) begin failures++; $display("FAIL prescale_24 got=%h exp=03", tmr0_reg_val); end
    repeat (7) cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h03) begin failures++; $display("FAIL prescale_31 got=%h exp=03", tmr0_reg_val); end
    cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h04) begin failures++; $display("FAIL prescale_32 got=%h exp=04", tmr0_reg_val); end
  endtask

  task automatic test_ext_falling;
    logic [7:0] base;
    cyc(0, 0, 1, 8'h38);
    cyc(0, 1, 0, 8'h40);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    base = 8'h40;
    for (int p = 0; p < 4; p++) begin
      t0cki = 1;
      repeat (S + 3) cyc(0, 0, 0, 0);
      checks++; if (tmr0_reg_val !== base) begin failures++; $display("FAIL ext_rising[%0d] got=%h exp=%h", p, tmr0_reg_val, base); end
      t0cki = 0;
      repeat (S) cyc(0, 0, 0, 0);
      checks++; if (tmr0_reg_val !== base) begin failures++; $display("FAIL ext_early[%0d] got=%h exp=%h", p, tmr0_reg_val, base); end
      cyc(0, 0, 0, 0);
      base = base + 8'd1;
      checks++; if (tmr0_reg_val !== base) begin failures++; $display("FAIL ext_fall[%0d] got=%h exp=%h", p, tmr0_reg_val, base); end
    end
  endtask

  task automatic test_write_vs_tick;
    if_cnt = 0;
    cyc(0, 0, 1, 8'h08);
    cyc(0, 1, 0, 8'hFF);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 8'h10);
    checks++; if (tmr0_reg_val !== 8'h10) begin failures++; $display("FAIL write_wins got=%h exp=10", tmr0_reg_val); end
    cyc(0, 0, 0, 0);
    checks++; if (if_cnt != 0) begin failures++; $display("FAIL write_no_t0if got=%0d exp=0", if_cnt); end
  endtask

  task automatic test_option_clears_prescaler;
    cyc(0, 0, 1, 8'h00);
    cyc(0, 1, 0, 8'h20);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h20) begin failures++; $display("FAIL opt_clear_1 got=%h exp=20", tmr0_reg_val); end
    cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h21) begin failures++; $display("FAIL opt_clear_2 got=%h exp=21", tmr0_reg_val); end
  endtask

  task automatic test_midcount_reset;
    cyc(0, 0, 1, 8'h08);
    cyc(0, 1, 0, 8'h78);
    repeat (4) cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h7A) begin failures++; $display("FAIL pre_reset got=%h exp=7A", tmr0_reg_val); end
    rst = 0;
    cyc(1, 1, 0, 8'h33);
    rst = 1;
    checks++; if (tmr0_reg_val !== 8'h00 || option_reg_val !== 8'hFF || t0if_set !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%h/%h/%b exp=00/FF/0", tmr0_reg_val, option_reg_val, t0if_set); end
    repeat (4) cyc(1, 0, 0, 0);
    checks++; if (tmr0_reg_val !== 8'h00) begin failures++; $display("FAIL post_reset_idle got=%h exp=00", tmr0_reg_val); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) t0cki = ~t0cki;
      cyc(logic'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0), 8'($urandom));
      checks++; if (tmr0_reg_val !== 8'(m_tmr)) begin failures++; $display("FAIL rand_tmr0[%0d] got=%h exp=%h", n, tmr0_reg_val, 8'(m_tmr)); end
      checks++; if (option_reg_val !== m_opt) begin failures++; $display("FAIL rand_option[%0d] got=%h exp=%h", n, option_reg_val, m_opt); end
      checks++; if (t0if_set !== m_if) begin failures++; $display("FAIL rand_t0if[%0d] got=%b exp=%b", n, t0if_set, m_if); end
    end
    rst = 1;
    t0cki = 0;
  endtask

  initial begin
    test_reset;
    test_inhibit_overflow;
    test_prescale_1to8;
    test_ext_falling;
    test_write_vs_tick;
    test_option_clears_prescaler;
    test_midcount_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
